// File: rtl/engine_stride_index_sequencer.sv
// Walks [index_start, index_end) by +/-stride, emitting Vertex-IDs tagged with meta and chunk/last flags.
// First beat 3 cycles after config handshake, then 1 beat/cycle; output register holds under !ready or pause.
module engine_stride_index_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int META_WIDTH = 32
) (
  input  logic                  i_ap_clk,
  input  logic                  i_areset,
  input  logic                  i_config_valid,
  input  logic [ADDR_WIDTH-1:0] i_config_index_start,
  input  logic [ADDR_WIDTH-1:0] i_config_index_end,
  input  logic [ADDR_WIDTH-1:0] i_config_stride,
  input  logic [ADDR_WIDTH-1:0] i_config_granularity,
  input  logic                  i_config_increment,
  input  logic                  i_config_decrement,
  input  logic [META_WIDTH-1:0] i_config_meta,
  output logic                  o_config_ready,
  input  logic                  i_pause,
  output logic                  o_index_out_valid,
  input  logic                  i_index_out_ready,
  output logic [ADDR_WIDTH-1:0] o_index_out_index,
  output logic [META_WIDTH-1:0] o_index_out_meta,
  output logic                  o_index_out_chunk_last,
  output logic                  o_index_out_last,
  output logic                  o_done,
  output logic                  o_busy
);

  typedef enum logic [2:0] {
    S_RESET, S_IDLE, S_SETUP, S_START, S_BUSY, S_PAUSE, S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cur;
  logic [ADDR_WIDTH-1:0] r_end;
  logic [ADDR_WIDTH-1:0] r_stride;
  logic [ADDR_WIDTH-1:0] r_gran;
  logic [ADDR_WIDTH-1:0] r_chunk_cnt;
  logic                  r_inc;
  logic                  r_dec;
  logic [META_WIDTH-1:0] r_meta;
  logic                  r_seq_end;
  logic                  r_out_valid;
  logic [ADDR_WIDTH-1:0] r_out_index;
  logic [META_WIDTH-1:0] r_out_meta;
  logic                  r_out_chunk_last;
  logic                  r_out_last;

  logic                  w_hs;
  logic                  w_launch;
  logic                  w_accept;
  logic                  w_slot_free;
  logic                  w_dir_up;
  logic                  w_dir_dn;
  logic                  w_empty;
  logic                  w_carry;
  logic [ADDR_WIDTH-1:0] w_sum;
  logic [ADDR_WIDTH-1:0] w_diff;
  logic [ADDR_WIDTH-1:0] w_next_cur;
  logic                  w_last;
  logic                  w_gran_end;
  logic                  w_chunk_last;

  assign w_accept    = r_out_valid && i_index_out_ready;
  assign w_slot_free = !r_out_valid || i_index_out_ready;
  assign w_dir_up    = r_inc && !r_dec;
  assign w_dir_dn    = r_dec && !r_inc;
  assign w_empty     = !(w_dir_up || w_dir_dn) ||
                       (w_dir_up && (r_cur >= r_end)) ||
                       (w_dir_dn && (r_cur <= r_end));

  // Carry out of the adder means the next up-index would wrap past the address space.
  assign {w_carry, w_sum} = {1'b0, r_cur} + {1'b0, r_stride};
  assign w_diff       = r_cur - r_stride;
  assign w_next_cur   = w_dir_up ? w_sum : w_diff;
  assign w_last       = w_dir_up ? (w_carry || (w_sum >= r_end))
                                 : ((r_cur < r_stride) || (w_diff <= r_end));
  assign w_gran_end   = (r_chunk_cnt == (r_gran - ONE));
  assign w_chunk_last = w_gran_end || w_last;

  always_ff @(posedge i_ap_clk or posedge i_areset) begin
    if (i_areset) r_state <= S_RESET;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hs        = 1'b0;
    w_launch    = 1'b0;
    case (r_state)
      S_RESET: w_state_nxt = S_IDLE;
      S_IDLE: begin
        if (i_config_valid) begin
          w_hs        = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: w_state_nxt = S_START;
      S_START: begin
        // The first beat is loaded on the way into BUSY so it is visible at T+3.
        if (w_empty)      w_state_nxt = S_DONE;
        else if (i_pause) w_state_nxt = S_PAUSE;
        else begin
          w_launch    = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_seq_end) begin
          if (w_accept)     w_state_nxt = S_DONE;
          else if (i_pause) w_state_nxt = S_PAUSE;
        end else if (i_pause) begin
          w_state_nxt = S_PAUSE;
        end else if (w_slot_free) begin
          w_launch = 1'b1;
        end
      end
      S_PAUSE: begin
        if (r_seq_end && w_accept) w_state_nxt = S_DONE;
        else if (!i_pause)         w_state_nxt = S_BUSY;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_RESET;
    endcase
  end

  always_ff @(posedge i_ap_clk or posedge i_areset) begin
    if (i_areset) begin
      r_cur            <= '0;
      r_end            <= '0;
      r_stride         <= '0;
      r_gran           <= '0;
      r_chunk_cnt      <= '0;
      r_inc            <= 1'b0;
      r_dec            <= 1'b0;
      r_meta           <= '0;
      r_seq_end        <= 1'b0;
      r_out_valid      <= 1'b0;
      r_out_index      <= '0;
      r_out_meta       <= '0;
      r_out_chunk_last <= 1'b0;
      r_out_last       <= 1'b0;
    end else begin
      if (w_hs) begin
        r_cur    <= i_config_index_start;
        r_end    <= i_config_index_end;
        r_stride <= i_config_stride;
        r_gran   <= i_config_granularity;
        r_inc    <= i_config_increment;
        r_dec    <= i_config_decrement;
        r_meta   <= i_config_meta;
      end
      if (r_state == S_SETUP) begin
        if (r_stride == '0) r_stride <= ONE;
        if (r_gran == '0)   r_gran   <= ONE;
        r_chunk_cnt <= '0;
        r_seq_end   <= 1'b0;
      end
      if (w_launch) begin
        r_out_valid      <= 1'b1;
        r_out_index      <= r_cur;
        r_out_meta       <= r_meta;
        r_out_chunk_last <= w_chunk_last;
        r_out_last       <= w_last;
        r_cur            <= w_next_cur;
        r_chunk_cnt      <= w_gran_end ? '0 : r_chunk_cnt + ONE;
        r_seq_end        <= w_last;
      end else if (w_accept) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_config_ready         = (r_state == S_IDLE);
  assign o_done                 = (r_state == S_DONE);
  assign o_busy                 = (r_state != S_IDLE) && (r_state != S_RESET);
  assign o_index_out_valid      = r_out_valid;
  assign o_index_out_index      = r_out_index;
  assign o_index_out_meta       = r_out_meta;
  assign o_index_out_chunk_last = r_out_chunk_last;
  assign o_index_out_last       = r_out_last;

endmodule

// File: tb/tb_engine_stride_index_sequencer.sv
// Directed bench for engine_stride_index_sequencer: hand-computed index streams, timing and reset cases.
module tb_engine_stride_index_sequencer;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic [31:0] cfg_start, cfg_end, cfg_stride, cfg_gran;
  logic        cfg_inc, cfg_dec;
  logic [7:0]  cfg_meta;
  logic        cfg_ready;
  logic        pause;
  logic        o_valid;
  logic        rdy;
  logic [31:0] o_index;
  logic [7:0]  o_meta;
  logic        o_cl, o_last, o_done, o_busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rdy_mode = 0;

  typedef struct {
    logic [31:0] idx;
    logic [7:0]  meta;
    logic        cl;
    logic        l;
    int          cyc;
  } beat_t;
  beat_t beats[$];
  int    dones[$];

  engine_stride_index_sequencer #(.ADDR_WIDTH(32), .META_WIDTH(8)) dut (
    .i_ap_clk(clk), .i_areset(rst),
    .i_config_valid(cfg_valid), .i_config_index_start(cfg_start),
    .i_config_index_end(cfg_end), .i_config_stride(cfg_stride),
    .i_config_granularity(cfg_gran), .i_config_increment(cfg_inc),
    .i_config_decrement(cfg_dec), .i_config_meta(cfg_meta),
    .o_config_ready(cfg_ready), .i_pause(pause),
    .o_index_out_valid(o_valid), .i_index_out_ready(rdy),
    .o_index_out_index(o_index), .o_index_out_meta(o_meta),
    .o_index_out_chunk_last(o_cl), .o_index_out_last(o_last),
    .o_done(o_done), .o_busy(o_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Consumer ready: always, toggled 1,0,0,1, or never.
  initial begin
    rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rdy = 1'b0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: records accepted beats and done pulses, checks hold stability and pause.
  initial begin
    logic        p_valid, p_rdy, p_pause, p_held, launch;
    logic [41:0] p_snap;
    p_valid = 1'b0; p_rdy = 1'b0; p_pause = 1'b0; p_held = 1'b0; p_snap = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_valid = 1'b0; p_rdy = 1'b0; p_pause = 1'b0; p_held = 1'b0;
      end else begin
        if (p_held)
          check("hold_stable", {21'd0, o_valid, o_index, o_meta, o_cl, o_last},
                {21'd0, 1'b1, p_snap});
        launch = o_valid && (!p_valid || p_rdy);
        if (p_pause) check("pause_launch", 64'(launch), 64'd0);
        if (o_valid && rdy) beats.push_back('{o_index, o_meta, o_cl, o_last, cyc});
        if (o_done) dones.push_back(cyc);
        p_held  = o_valid && !rdy;
        p_snap  = {o_index, o_meta, o_cl, o_last};
        p_valid = o_valid;
        p_rdy   = rdy;
        p_pause = pause;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                           input logic [31:0] g, input logic inc, input logic dec,
                           input logic [7:0] m);
    cfg_start = s; cfg_end = e; cfg_stride = st; cfg_gran = g;
    cfg_inc = inc; cfg_dec = dec; cfg_meta = m; cfg_valid = 1'b1;
  endtask

  task automatic wait_hs(output int t);
    bit found;
    found = 0;
    t = -1;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (cfg_ready && cfg_valid) begin
        found = 1;
        t = cyc;
      end
    end
    if (!found) check("hs_timeout", 64'd0, 64'd1);
  endtask

  task automatic drop_valid();
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input int n);
    bit found;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (dones.size() >= n) found = 1;
    end
    if (!found) check("done_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input int k, input logic [31:0] idx, input logic [7:0] meta,
                            input logic cl, input logic l);
    if (k < beats.size())
      check($sformatf("beat%0d", k), {22'd0, beats[k].idx, beats[k].meta, beats[k].cl, beats[k].l},
            {22'd0, idx, meta, cl, l});
    else
      check($sformatf("beat%0d_missing", k), 64'd0, 64'd1);
  endtask

  task automatic clear_logs();
    beats.delete();
    dones.delete();
  endtask

  initial begin
    int t, tb;
    bit found;
    rst = 1'b1; pause = 1'b0;
    cfg_valid = 1'b0; cfg_start = '0; cfg_end = '0; cfg_stride = '0; cfg_gran = '0;
    cfg_inc = 1'b0; cfg_dec = 1'b0; cfg_meta = '0;
    repeat (3) @(negedge clk);
    check("rst_cfg_ready", 64'(cfg_ready), 64'd0);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_index", 64'(o_index), 64'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Up 0..10 stride 1 gran 4
    clear_logs();
    drive_cfg(32'd0, 32'd10, 32'd1, 32'd4, 1'b1, 1'b0, 8'hA1);
    wait_hs(t); drop_valid(); wait_done(1);
    check("t1_count", 64'(beats.size()), 64'd10);
    for (int i = 0; i < 10; i++)
      check_beat(i, 32'(i), 8'hA1, (i == 3) || (i == 7) || (i == 9), i == 9);
    if (beats.size() > 0) begin
      check("t1_first_valid", 64'(beats[0].cyc), 64'(t + 3));
      check("t1_done_cycle", 64'(dones[0]), 64'(beats[beats.size()-1].cyc + 1));
    end

    // Down 20..4 stride 5 gran 2
    clear_logs();
    drive_cfg(32'd20, 32'd4, 32'd5, 32'd2, 1'b0, 1'b1, 8'hB2);
    wait_hs(t); drop_valid(); wait_done(1);
    check("t2_count", 64'(beats.size()), 64'd4);
    check_beat(0, 32'd20, 8'hB2, 1'b0, 1'b0);
    check_beat(1, 32'd15, 8'hB2, 1'b1, 1'b0);
    check_beat(2, 32'd10, 8'hB2, 1'b0, 1'b0);
    check_beat(3, 32'd5,  8'hB2, 1'b1, 1'b1);

    // Ready 1,0,0,1 with a 5-cycle pause mid-stream: 100..111 gran 3
    clear_logs();
    rdy_mode = 1;
    drive_cfg(32'd100, 32'd112, 32'd1, 32'd3, 1'b1, 1'b0, 8'hC3);
    wait_hs(t); drop_valid();
    repeat (6) @(posedge clk);
    #1; pause = 1'b1;
    repeat (5) @(posedge clk);
    #1; pause = 1'b0;
    wait_done(1);
    rdy_mode = 0;
    check("t3_count", 64'(beats.size()), 64'd12);
    for (int i = 0; i < 12; i++)
      check_beat(i, 32'(100 + i), 8'hC3, (i % 3) == 2, i == 11);
    if (beats.size() > 0)
      check("t3_done_cycle", 64'(dones[0]), 64'(beats[beats.size()-1].cyc + 1));

    // Stride 0 and granularity 0 both normalise to 1
    clear_logs();
    drive_cfg(32'd5, 32'd8, 32'd0, 32'd0, 1'b1, 1'b0, 8'h17);
    wait_hs(t); drop_valid(); wait_done(1);
    check("t4_count", 64'(beats.size()), 64'd3);
    check_beat(0, 32'd5, 8'h17, 1'b1, 1'b0);
    check_beat(1, 32'd6, 8'h17, 1'b1, 1'b0);
    check_beat(2, 32'd7, 8'h17, 1'b1, 1'b1);

    // Top of address space: carry out terminates after one beat
    clear_logs();
    drive_cfg(32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd4, 32'd4, 1'b1, 1'b0, 8'h29);
    wait_hs(t); drop_valid(); wait_done(1);
    check("t5_count", 64'(beats.size()), 64'd1);
    check_beat(0, 32'hFFFF_FFFD, 8'h29, 1'b1, 1'b1);

    // Empty range start == end
    clear_logs();
    drive_cfg(32'd8, 32'd8, 32'd1, 32'd4, 1'b1, 1'b0, 8'h33);
    wait_hs(t); drop_valid(); wait_done(1);
    check("t6_count", 64'(beats.size()), 64'd0);
    check("t6_done_cycle", 64'(dones[0]), 64'(t + 3));

    // Invalid direction
    clear_logs();
    drive_cfg(32'd0, 32'd10, 32'd1, 32'd4, 1'b1, 1'b1, 8'h44);
    wait_hs(t); drop_valid(); wait_done(1);
    check("t7_count", 64'(beats.size()), 64'd0);
    check("t7_done_cycle", 64'(dones[0]), 64'(t + 3));

    // Reset while beat index 2 is pending, then a clean restart
    clear_logs();
    drive_cfg(32'd0, 32'd10, 32'd1, 32'd4, 1'b1, 1'b0, 8'h55);
    wait_hs(t); drop_valid();
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (o_valid && o_index == 32'd2) found = 1;
    end
    check("t8_reach_beat2", 64'(found), 64'd1);
    rst = 1'b1;
    #1;
    check("t8_valid_drop", 64'(o_valid), 64'd0);
    check("t8_busy_drop", 64'(o_busy), 64'd0);
    check("t8_ready_in_reset", 64'(cfg_ready), 64'd0);
    clear_logs();
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    drive_cfg(32'd40, 32'd43, 32'd1, 32'd2, 1'b1, 1'b0, 8'hD4);
    wait_hs(t); drop_valid(); wait_done(1);
    check("t8_done_count", 64'(dones.size()), 64'd1);
    check("t8_count", 64'(beats.size()), 64'd3);
    check_beat(0, 32'd40, 8'hD4, 1'b0, 1'b0);
    check_beat(1, 32'd41, 8'hD4, 1'b1, 1'b0);
    check_beat(2, 32'd42, 8'hD4, 1'b1, 1'b1);

    // Back-to-back: second config held valid during the first sequence
    clear_logs();
    drive_cfg(32'd0, 32'd3, 32'd1, 32'd1, 1'b1, 1'b0, 8'hE5);
    wait_hs(t);
    @(posedge clk); #1;
    drive_cfg(32'd50, 32'd52, 32'd1, 32'd2, 1'b1, 1'b0, 8'hF6);
    wait_hs(tb); drop_valid(); wait_done(2);
    check("t9_done_count", 64'(dones.size()), 64'd2);
    if (dones.size() > 0) check("t9_second_hs", 64'(tb), 64'(dones[0] + 1));
    check("t9_count", 64'(beats.size()), 64'd5);
    check_beat(0, 32'd0,  8'hE5, 1'b1, 1'b0);
    check_beat(1, 32'd1,  8'hE5, 1'b1, 1'b0);
    check_beat(2, 32'd2,  8'hE5, 1'b1, 1'b1);
    check_beat(3, 32'd50, 8'hF6, 1'b0, 1'b0);
    check_beat(4, 32'd51, 8'hF6, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/engine_stride_index_sequencer.md
# engine_stride_index_sequencer

Consumes one `StrideIndexConfiguration` from the configuration path and emits the resulting sequence of Vertex-IDs as a valid/ready stream toward the read/write engines and Vertex-CUs. Indices are tagged with the configuration's `MemoryPacketMeta` and grouped into chunks of `granularity` entries. It sits directly downstream of the CU setup/configuration stage and upstream of the read/write engines.

## Interface
- `ADDR_WIDTH`, default `M_AXI_MEMORY_ADDR_WIDTH`: width of index and all numeric config fields.
- `ap_clk` in 1: single clock; all logic rising-edge.
- `areset` in 1: asynchronous, active-high reset.
- `config_in` in `StrideIndexConfiguration`: configuration word; `valid` qualifies it.
- `config_ready_out` out 1: high only in IDLE; config accepted on `config_in.valid && config_ready_out`.
- `pause_in` in 1: holds generation while high.
- `index_out_valid` out 1: output beat valid.
- `index_out_ready` in 1: consumer accepts beat.
- `index_out_index` out `ADDR_WIDTH`: generated Vertex-ID.
- `index_out_meta` out `MemoryPacketMeta`: meta copied from accepted config.
- `index_out_chunk_last` out 1: last index of a granularity chunk, or final index of sequence.
- `index_out_last` out 1: final index of the sequence.
- `done_out` out 1: one-cycle pulse when the sequence completes.
- `busy_out` out 1: high in every state except IDLE and RESET.

## Operation
- States: RESET -> IDLE -> SETUP -> START -> BUSY <-> PAUSE -> DONE -> IDLE.
- RESET: entered on `areset`; leaves to IDLE on the first clock after deassert.
- IDLE: `config_ready_out`=1; on handshake, latch param and meta -> SETUP.
- SETUP: normalise fields. `stride`=0 becomes 1; `granularity`=0 becomes 1. `cur`=index_start; `chunk_cnt`=0. Direction is up if `increment`&&!`decrement`, down if `decrement`&&!`increment`, otherwise invalid. -> START.
- START: if direction invalid, or the range is empty, -> DONE with no beats. Range is empty if up and `index_start`>=`index_end`, or down and `index_start`<=`index_end`. Otherwise -> BUSY.
- BUSY: launch a beat when the output register is empty or being accepted this cycle, and `pause_in`=0.
  - Beat fields: `index_out_index`=cur.
  - `index_out_last` is set when the next index is out of range:
    - up: `cur+stride`>=`index_end`, or the addition carries out of ADDR_WIDTH;
    - down: `cur`<`stride`, or `cur-stride`<=`index_end`.
  - `index_out_chunk_last` = (`chunk_cnt`==granularity-1) || last.
  - `chunk_cnt` wraps to 0 after granularity-1. `cur` steps by ±stride.
  - After launching the last beat -> DONE once that beat is accepted.
- PAUSE: entered from BUSY when `pause_in`=1. No new launches; an already-valid beat stays valid and may still be accepted. Returns to BUSY the cycle after `pause_in` falls.
- DONE: `done_out`=1 for exactly one cycle -> IDLE.
- Config arriving while not in IDLE is not accepted; the upstream stage holds it.

## Timing
- Reset values: `config_ready_out`=0 (while in RESET), `index_out_valid`=0, index/meta/flags=0, `done_out`=0, `busy_out`=0, state=RESET.
- Reset mid-sequence clears all state immediately, including the pending output beat. No `done_out` is produced for the aborted sequence.
- Latency: config handshake at cycle T; first `index_out_valid` at T+3.
- Throughput: 1 index/cycle with `index_out_ready` held high.
- Output stability: once `index_out_valid`=1, index, meta and flags stay stable until accepted.
- `pause_in` is sampled at the clock edge. A `pause_in` high in cycle N prevents a launch at edge N+1.
- `done_out` asserts the cycle after the last beat is accepted, or at T+3 for an empty or invalid config.
- Simultaneous accept and launch in the same cycle is required; there is no bubble.

## Test plan
- Config up, start=0, end=10, stride=1, gran=4 -> indices 0..9; chunk_last on 3, 7, 9; last on 9; first valid at T+3; done 1 cycle after 9 accepted.
- Config down, start=20, end=4, stride=5, gran=2 -> 20, 15, 10, 5; chunk_last on 15 and 5; last on 5.
- `index_out_ready` toggled 1,0,0,1 repeating and `pause_in` high for 5 cycles mid-stream -> no beat lost or duplicated; held beat stable; no launch during pause.
- Boundaries:
  - start=end=8 -> zero beats, done at T+3;
  - increment=decrement=1 -> zero beats, done;
  - stride=0 -> treated as 1;
  - up start=2^W-3, end=2^W-1, stride=4 -> single beat 2^W-3 with last.
- `areset` asserted while beat 3 of 10 is pending -> valid drops immediately; next config accepted cleanly and restarts from its own index_start.
- Back-to-back configs: second `config_in.valid` held during the first sequence -> accepted only in IDLE after `done_out`; meta on second stream matches second config.
